// File: rtl/spimemio_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spimemio_arbiter_if : bus bundle between requesters, config and flash |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface spimemio_arbiter_if;
  logic        m0_valid;
  logic        m0_ready;
  logic [23:0] m0_addr;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic        m1_ready;
  logic [23:0] m1_addr;
  logic [31:0] m1_rdata;

  logic        mem_valid;
  logic        mem_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;

  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_we;
  logic [31:0] cfg_di;
  logic [3:0]  cfgreg_we;
  logic [31:0] cfgreg_di;

  // Arbiter side of the bundle.
  modport slave (
    input  m0_valid, m0_addr, m1_valid, m1_addr,
    input  mem_ready, mem_rdata,
    input  cfg_valid, cfg_we, cfg_di,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output mem_valid, mem_addr,
    output cfg_ready, cfgreg_we, cfgreg_di
  );

  // Environment side: bus decoder, requesters and spimemio.
  modport master (
    output m0_valid, m0_addr, m1_valid, m1_addr,
    output mem_ready, mem_rdata,
    output cfg_valid, cfg_we, cfg_di,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  mem_valid, mem_addr,
    input  cfg_ready, cfgreg_we, cfgreg_di
  );
endinterface
`default_nettype wire

// File: rtl/spimemio_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spimemio_arbiter : sticky two-port read arbiter with config serialiser|
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module spimemio_arbiter #(
  parameter int BURST_MAX = 8,
  parameter bit PRIO      = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  spimemio_arbiter_if.slave     io_bus
);

  localparam logic [3:0] c_BURST_MAX = 4'(BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_CFG    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic [3:0] r_streak;
  logic [3:0] w_streak_nxt;
  logic [3:0] w_streak_sat;
  logic       w_pick;
  logic       w_done;
  logic       w_done_port;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_last   <= PRIO;
      r_streak <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Saturating increment; the counter never wraps past the burst limit.
  assign w_streak_sat = (r_streak >= c_BURST_MAX) ? c_BURST_MAX : (r_streak + 4'd1);

  always_comb begin
    w_state_nxt      = r_state;
    w_pick           = r_last;
    w_done           = 1'b0;
    w_done_port      = 1'b0;

    io_bus.mem_valid = 1'b0;
    io_bus.mem_addr  = 24'd0;
    io_bus.m0_ready  = 1'b0;
    io_bus.m0_rdata  = 32'd0;
    io_bus.m1_ready  = 1'b0;
    io_bus.m1_rdata  = 32'd0;
    io_bus.cfg_ready = 1'b0;
    io_bus.cfgreg_we = 4'd0;
    io_bus.cfgreg_di = 32'd0;

    case (r_state)
      ST_IDLE: begin
        if (io_bus.cfg_valid) begin
          w_state_nxt = ST_CFG;
        end else if (io_bus.m0_valid && !io_bus.m1_valid) begin
          w_state_nxt = ST_GRANT0;
        end else if (io_bus.m1_valid && !io_bus.m0_valid) begin
          w_state_nxt = ST_GRANT1;
        end else if (io_bus.m0_valid && io_bus.m1_valid) begin
          // Stay with the last-served port until it has used up its burst.
          w_pick      = (r_streak >= c_BURST_MAX) ? ~r_last : r_last;
          w_state_nxt = w_pick ? ST_GRANT1 : ST_GRANT0;
        end
      end

      ST_GRANT0: begin
        io_bus.mem_valid = io_bus.m0_valid;
        io_bus.mem_addr  = io_bus.m0_addr;
        io_bus.m0_ready  = io_bus.mem_ready;
        io_bus.m0_rdata  = io_bus.mem_rdata;
        if (!io_bus.m0_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (io_bus.mem_ready) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
          w_done_port = 1'b0;
        end
      end

      ST_GRANT1: begin
        io_bus.mem_valid = io_bus.m1_valid;
        io_bus.mem_addr  = io_bus.m1_addr;
        io_bus.m1_ready  = io_bus.mem_ready;
        io_bus.m1_rdata  = io_bus.mem_rdata;
        if (!io_bus.m1_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (io_bus.mem_ready) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
          w_done_port = 1'b1;
        end
      end

      ST_CFG: begin
        io_bus.cfg_ready = 1'b1;
        io_bus.cfgreg_we = io_bus.cfg_we;
        io_bus.cfgreg_di = io_bus.cfg_di;
        w_state_nxt      = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Only completed grants move the fairness bookkeeping; aborts leave it alone.
  always_comb begin
    w_last_nxt   = r_last;
    w_streak_nxt = r_streak;
    if (w_done) begin
      if (w_done_port == r_last) begin
        w_streak_nxt = w_streak_sat;
      end else begin
        w_streak_nxt = 4'd1;
        w_last_nxt   = w_done_port;
      end
    end
  end

endmodule
`default_nettype wire
